// File: rtl/bloonstd1_soc_timer_host.sv
// rtl/bloonstd1_soc_timer_host.sv - Avalon-MM initiator that programs and services the SoC interval timer
//
// Purpose:
//   After reset, writes the timer period (addresses 2..5) and then the control
//   register (address 1) to start it. Each timer interrupt is acknowledged by a
//   status write (address 0), which raises a one-cycle tick and advances
//   tick_count. Fabric logic can change the period (cfg_*) or request a counter
//   snapshot (snap_*) through valid/ready handshakes.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_period    runtime period change
//   snap_valid_req/snap_ready         snapshot request
//   snap_valid, snap_value            one-cycle result pulse, held value
//   tick, tick_count                  per-service pulse, wrapping service count
//   busy                              high whenever the FSM is not in IDLE
//   avm_address/chipselect/write_n/writedata/readdata   Avalon-MM initiator
//   timer_irq                         level interrupt from the timer

module bloonstd1_soc_timer_host #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
    parameter logic        CONTINUOUS     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_period,
    input  logic        snap_valid_req,
    output logic        snap_ready,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        busy,
    output logic [3:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        timer_irq
);

    typedef enum logic [3:0] {
        S_PRG_P0,
        S_PRG_P1,
        S_PRG_P2,
        S_PRG_P3,
        S_PRG_CTL,
        S_IDLE,
        S_CLR,
        S_CLR_GUARD,
        S_SNAP_W,
        S_SNAP_R0A,
        S_SNAP_R0B,
        S_SNAP_R1A,
        S_SNAP_R1B,
        S_SNAP_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] period;
    logic [31:0] period_next;
    logic        cfg_hs;
    logic [15:0] snap_lo;

    logic [3:0]  bus_address_next;
    logic        bus_chipselect_next;
    logic        bus_write_n_next;
    logic [15:0] bus_writedata_next;

    assign busy       = (state != S_IDLE);
    assign cfg_ready  = (state == S_IDLE) && !timer_irq;
    assign snap_ready = cfg_ready && !cfg_valid;
    assign tick       = (state == S_CLR);
    assign snap_valid = (state == S_SNAP_DONE);

    always_comb begin
        state_next = state;
        cfg_hs     = 1'b0;
        case (state)
            // The bus register is loaded with the command of the state being
            // entered, so a state's command is on the bus while in that state.
            // Reset leaves the bus idle in PRG_P0, so PRG_P0 holds for one
            // cycle until its own write is actually presented.
            S_PRG_P0:    state_next = avm_chipselect ? S_PRG_P1 : S_PRG_P0;
            S_PRG_P1:    state_next = S_PRG_P2;
            S_PRG_P2:    state_next = S_PRG_P3;
            S_PRG_P3:    state_next = S_PRG_CTL;
            S_PRG_CTL:   state_next = S_IDLE;
            S_IDLE: begin
                if (timer_irq) begin
                    state_next = S_CLR;
                end else if (cfg_valid) begin
                    cfg_hs     = 1'b1;
                    state_next = S_PRG_P0;
                end else if (snap_valid_req) begin
                    state_next = S_SNAP_W;
                end
            end
            S_CLR:       state_next = S_CLR_GUARD;
            // The slave drops timer_irq only after seeing the status write,
            // so the level is not trusted during this cycle.
            S_CLR_GUARD: state_next = S_IDLE;
            S_SNAP_W:    state_next = S_SNAP_R0A;
            S_SNAP_R0A:  state_next = S_SNAP_R0B;
            S_SNAP_R0B:  state_next = S_SNAP_R1A;
            S_SNAP_R1A:  state_next = S_SNAP_R1B;
            S_SNAP_R1B:  state_next = S_SNAP_DONE;
            S_SNAP_DONE: state_next = S_IDLE;
            default:     state_next = S_PRG_P0;
        endcase
    end

    assign period_next = cfg_hs ? cfg_period : period;

    always_comb begin
        bus_address_next    = 4'd0;
        bus_chipselect_next = 1'b0;
        bus_write_n_next    = 1'b1;
        bus_writedata_next  = 16'd0;
        case (state_next)
            S_PRG_P0: begin
                bus_chipselect_next = 1'b1;
                bus_write_n_next    = 1'b0;
                bus_address_next    = 4'd2;
                bus_writedata_next  = period_next[15:0];
            end
            S_PRG_P1: begin
                bus_chipselect_next = 1'b1;
                bus_write_n_next    = 1'b0;
                bus_address_next    = 4'd3;
                bus_writedata_next  = period_next[31:16];
            end
            S_PRG_P2: begin
                bus_chipselect_next = 1'b1;
                bus_write_n_next    = 1'b0;
                bus_address_next    = 4'd4;
            end
            S_PRG_P3: begin
                bus_chipselect_next = 1'b1;
                bus_write_n_next    = 1'b0;
                bus_address_next    = 4'd5;
            end
            S_PRG_CTL: begin
                bus_chipselect_next = 1'b1;
                bus_write_n_next    = 1'b0;
                bus_address_next    = 4'd1;
                bus_writedata_next  = {12'd0, 1'b0, 1'b1, CONTINUOUS, 1'b1};
            end
            S_CLR: begin
                bus_chipselect_next = 1'b1;
                bus_write_n_next    = 1'b0;
                bus_address_next    = 4'd0;
            end
            S_SNAP_W: begin
                bus_chipselect_next = 1'b1;
                bus_write_n_next    = 1'b0;
                bus_address_next    = 4'd6;
            end
            S_SNAP_R0A, S_SNAP_R0B: begin
                bus_chipselect_next = 1'b1;
                bus_address_next    = 4'd6;
            end
            S_SNAP_R1A, S_SNAP_R1B: begin
                bus_chipselect_next = 1'b1;
                bus_address_next    = 4'd7;
            end
            default: begin
                bus_chipselect_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_PRG_P0;
            period         <= DEFAULT_PERIOD;
            avm_address    <= 4'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 16'd0;
            tick_count     <= 16'd0;
            snap_lo        <= 16'd0;
            snap_value     <= 32'd0;
        end else begin
            state          <= state_next;
            period         <= period_next;
            avm_address    <= bus_address_next;
            avm_chipselect <= bus_chipselect_next;
            avm_write_n    <= bus_write_n_next;
            avm_writedata  <= bus_writedata_next;
            if (state == S_CLR) begin
                tick_count <= tick_count + 16'd1;
            end
            // Low half is parked so snap_value only changes as a whole word.
            if (state == S_SNAP_R0B) begin
                snap_lo <= avm_readdata;
            end
            if (state == S_SNAP_R1B) begin
                snap_value <= {avm_readdata, snap_lo};
            end
        end
    end

endmodule

// File: tb/tb_bloonstd1_soc_timer_host.sv
// tb/tb_bloonstd1_soc_timer_host.sv - self-checking bench for bloonstd1_soc_timer_host with a behavioural timer slave

module tb_bloonstd1_soc_timer_host;

    localparam logic [31:0] DEF_P = 32'd49999;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_period;
    logic        snap_valid_req;
    logic        snap_ready;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic        tick;
    logic [15:0] tick_count;
    logic        busy;
    logic [3:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        timer_irq;

    always #5 clk = ~clk;

    bloonstd1_soc_timer_host #(.DEFAULT_PERIOD(DEF_P), .CONTINUOUS(1'b1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .snap_valid_req (snap_valid_req),
        .snap_ready     (snap_ready),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick           (tick),
        .tick_count     (tick_count),
        .busy           (busy),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .timer_irq      (timer_irq)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural interval-timer slave ----------------
    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wlog[$];
    wr_t         w_tmp;
    logic [31:0] tm_period;
    logic [31:0] tm_counter;
    logic [31:0] tm_snap;
    logic        tm_running;
    logic        tm_to;
    logic        tm_ito;
    logic        tm_cont;
    logic [15:0] tm_wr16;
    int          tm_irq_rise_cyc;

    assign timer_irq = tm_to & tm_ito;

    function automatic logic [15:0] tm_reg(input logic [3:0] a);
        case (a)
            4'd0:    return {14'd0, tm_running, tm_to};
            4'd2:    return tm_period[15:0];
            4'd3:    return tm_period[31:16];
            4'd6:    return tm_snap[15:0];
            4'd7:    return tm_snap[31:16];
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_period       <= 32'd0;
            tm_counter      <= 32'd0;
            tm_snap         <= 32'd0;
            tm_running      <= 1'b0;
            tm_to           <= 1'b0;
            tm_ito          <= 1'b0;
            tm_cont         <= 1'b0;
            tm_wr16         <= 16'd0;
            avm_readdata    <= 16'd0;
        end else begin
            avm_readdata <= avm_chipselect ? tm_reg(avm_address) : 16'd0;
            if (tm_running) begin
                if (tm_counter == 32'd0) begin
                    tm_counter <= tm_period;
                    tm_to      <= 1'b1;
                    if (!tm_to) tm_irq_rise_cyc <= cyc + 1;
                    if (!tm_cont) tm_running <= 1'b0;
                end else begin
                    tm_counter <= tm_counter - 32'd1;
                end
            end
            if (avm_chipselect && !avm_write_n) begin
                w_tmp.cyc  = cyc;
                w_tmp.addr = avm_address;
                w_tmp.data = avm_writedata;
                wlog.push_back(w_tmp);
                case (avm_address)
                    4'd0: begin
                        tm_to   <= 1'b0;
                        tm_wr16 <= tm_wr16 + 16'd1;
                    end
                    4'd1: begin
                        tm_ito  <= avm_writedata[0];
                        tm_cont <= avm_writedata[1];
                        if (avm_writedata[2]) tm_running <= 1'b1;
                        if (avm_writedata[3]) tm_running <= 1'b0;
                    end
                    4'd2: begin
                        tm_period  <= {tm_period[31:16], avm_writedata};
                        tm_counter <= {tm_period[31:16], avm_writedata};
                        tm_running <= 1'b0;
                    end
                    4'd3: begin
                        tm_period  <= {avm_writedata, tm_period[15:0]};
                        tm_counter <= {avm_writedata, tm_period[15:0]};
                        tm_running <= 1'b0;
                    end
                    4'd4, 4'd5: begin
                        tm_counter <= tm_period;
                        tm_running <= 1'b0;
                    end
                    4'd6, 4'd7, 4'd8, 4'd9: tm_snap <= tm_counter;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle rule checker ----------------
    logic [15:0] cnt_offset = 16'd0;
    logic [15:0] exp_cnt;
    assign exp_cnt = tm_wr16 + cnt_offset;

    int   snap_hs_cyc = -100;
    int   snap_pulses = 0;
    logic prev_tick = 1'b0;
    logic prev_idle_irq = 1'b0;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("tick_is_status_write", tick, avm_chipselect && !avm_write_n && (avm_address == 4'd0));
            chk("tick_count_vs_services", tick_count, exp_cnt);
            chk("tick_follows_idle_irq", tick, prev_idle_irq);
            chk("cfg_ready_rule", cfg_ready, !busy && !timer_irq);
            chk("snap_ready_rule", snap_ready, cfg_ready && !cfg_valid);
            if (!avm_chipselect)
                chk("bus_idle_value", {avm_address, avm_write_n, avm_writedata}, {4'd0, 1'b1, 16'd0});
            if (prev_tick)
                chk("irq_low_after_status_write", timer_irq, 1'b0);
            if (snap_valid) begin
                snap_pulses++;
                chk("snap_value_vs_latch", snap_value, tm_snap);
                chk("snap_latency", cyc - snap_hs_cyc, 6);
            end
            prev_tick     = tick;
            prev_idle_irq = !busy && timer_irq;
        end else begin
            prev_tick     = 1'b0;
            prev_idle_irq = 1'b0;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk_wr(input string n, input int c, input logic [3:0] a, input logic [15:0] d);
        int idx = -1;
        foreach (wlog[i]) if (wlog[i].cyc == c) idx = i;
        if (idx < 0) chk({n, "_present"}, 32'd0, 32'd1);
        else chk(n, {12'd0, wlog[idx].addr, wlog[idx].data}, {12'd0, a, d});
    endtask

    task automatic prg_seq(input string n, input int c0, input logic [31:0] p);
        chk_wr({n, "_w2"}, c0 + 1, 4'd2, p[15:0]);
        chk_wr({n, "_w3"}, c0 + 2, 4'd3, p[31:16]);
        chk_wr({n, "_w4"}, c0 + 3, 4'd4, 16'd0);
        chk_wr({n, "_w5"}, c0 + 4, 4'd5, 16'd0);
        chk_wr({n, "_ctl"}, c0 + 5, 4'd1, 16'h0007);
    endtask

    task automatic chk_rst(input string n);
        chk({n, "_busy"}, busy, 1'b1);
        chk({n, "_cfg_ready"}, cfg_ready, 1'b0);
        chk({n, "_snap_ready"}, snap_ready, 1'b0);
        chk({n, "_tick"}, tick, 1'b0);
        chk({n, "_tick_count"}, tick_count, 16'd0);
        chk({n, "_snap_valid"}, snap_valid, 1'b0);
        chk({n, "_snap_value"}, snap_value, 32'd0);
        chk({n, "_bus"}, {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b0, 1'b1, 4'd0, 16'd0});
    endtask

    task automatic do_cfg(input logic [31:0] p, output int h);
        int n = 0;
        cfg_valid  = 1'b1;
        cfg_period = p;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) chk("cfg_handshake_timeout", 32'd0, 32'd1);
        h = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_snap(output int h);
        int n = 0;
        snap_valid_req = 1'b1;
        while (!snap_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!snap_ready) chk("snap_handshake_timeout", 32'd0, 32'd1);
        h = cyc;
        snap_hs_cyc = h;
        @(negedge clk);
        snap_valid_req = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int tc);
        tc = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (tick) begin
                tc = cyc;
                return;
            end
        end
        chk("tick_wait_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int h, h2, r0, t_prev, t_cur, nt, tcyc, c0, pulses0, pcyc;
        logic [31:0] pval;
        reset_n        = 1'b0;
        cfg_valid      = 1'b0;
        cfg_period     = 32'd0;
        snap_valid_req = 1'b0;

        repeat (3) @(negedge clk);
        chk_rst("reset");

        r0 = cyc;
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("busy_after_release_c%0d", k), busy, (k < 6) ? 1'b1 : 1'b0);
        end
        prg_seq("reset_prog", r0, DEF_P);
        chk_wr("reset_prog_lit_w2", r0 + 1, 4'd2, 16'hC34F);

        // period 9: ticks every 10 cycles
        do_cfg(32'd9, h);
        repeat (5) @(negedge clk);
        prg_seq("cfg9", h, 32'd9);
        wait_tick(60, t_prev);
        for (int i = 1; i < 5; i++) begin
            wait_tick(40, t_cur);
            chk($sformatf("tick_spacing_%0d", i), t_cur - t_prev, 10);
            t_prev = t_cur;
        end
        @(negedge clk);
        chk("tick_count_five", tick_count, 16'd5);

        // irq rises during PRG_P1 of a cfg sequence
        for (int n = 0; n < 40; n++) begin
            if (tm_counter == 32'd1 && !timer_irq && !busy) break;
            @(negedge clk);
        end
        c0 = cyc;
        do_cfg(32'd9, h);
        chk("irq_p1_immediate_hs", h, c0);
        nt = 0;
        tcyc = -1;
        while (cyc <= h + 8) begin
            if (tick) begin
                nt++;
                tcyc = cyc;
            end
            @(negedge clk);
        end
        chk("irq_p1_rise_cycle", tm_irq_rise_cyc, h + 2);
        prg_seq("irq_p1_prog", h, 32'd9);
        chk("irq_p1_one_tick", nt, 1);
        chk("irq_p1_tick_cycle", tcyc, h + 7);

        // period 0x0001_0003
        do_cfg(32'h0001_0003, h);
        repeat (5) @(negedge clk);
        prg_seq("cfg10003", h, 32'h0001_0003);
        chk_wr("cfg10003_lit_w2", h + 1, 4'd2, 16'h0003);
        chk_wr("cfg10003_lit_w3", h + 2, 4'd3, 16'h0001);

        // snapshot with counter 0x0001_2345 during SNAP_W
        do_cfg(32'h0001_3000, h);
        repeat (5) @(negedge clk);
        for (int n = 0; n < 5000; n++) begin
            if (tm_counter == 32'h0001_2346) break;
            @(negedge clk);
        end
        chk("snap_counter_reached", tm_counter, 32'h0001_2346);
        c0 = cyc;
        do_snap(h2);
        chk("snap_immediate_hs", h2, c0);
        pulses0 = snap_pulses;
        pcyc = -1;
        pval = 32'd0;
        while (cyc <= h2 + 7) begin
            if (snap_valid) begin
                pcyc = cyc;
                pval = snap_value;
            end
            @(negedge clk);
        end
        chk("snap_pulse_cycle", pcyc, h2 + 6);
        chk("snap_value_literal", pval, 32'h0001_2345);
        chk("snap_single_pulse", snap_pulses - pulses0, 1);
        chk("snap_value_held", snap_value, 32'h0001_2345);

        // reset during SNAP_R0B
        do_snap(h2);
        @(negedge clk);
        @(negedge clk);
        pulses0 = snap_pulses;
        reset_n = 1'b0;
        #1;
        chk_rst("reset_in_r0b");
        repeat (3) @(negedge clk);
        r0 = cyc;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_snap_after_abort", snap_pulses - pulses0, 0);
        chk("busy_low_after_reprog", busy, 1'b0);
        prg_seq("reprog", r0, DEF_P);

        // tick_count wrap from 0xFFFF
        @(posedge clk);
        #2;
        force dut.tick_count = 16'hFFFF;
        cnt_offset = 16'hFFFF - tm_wr16;
        @(posedge clk);
        #2;
        release dut.tick_count;
        @(negedge clk);
        chk("tick_count_preset", tick_count, 16'hFFFF);
        do_cfg(32'd9, h);
        wait_tick(60, t_cur);
        @(negedge clk);
        chk("tick_count_wrap", tick_count, 16'h0000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
